soc_sram_sp_arbiter: RTL and testbench
======================================

Name: soc_sram_sp_arbiter

Overview:
- Two-requester arbiter and sequencer for one single-port, byte-selectable SRAM with a 1-cycle registered read.
- Sits between the instruction-fetch and data-access masters of a compute tile and one shared on-tile SRAM.
- Grants one access at a time, drives the SRAM control, address and data lines, and returns the ack and read data to the winner.
- Guarantees that the SRAM write strobe is asserted only in the issue cycle.

Parameters:
- DW, 32, data width; must be 8, 16 or 32.
- SW, localparam, byte-select width: 4 for DW=32, 2 for DW=16, 1 for DW=8.
- WORD_AW, 30, word address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request; held with its qualifiers until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_waddr  in  WORD_AW  master 0 word address
- m0_din  in  DW  master 0 write data
- m0_sel  in  SW  master 0 byte selects
- m0_ack  out  1  master 0 one-cycle completion pulse
- m1_req, m1_we, m1_waddr, m1_din, m1_sel, m1_ack  same as master 0, for master 1
- rdata  out  DW  read data, shared by both masters; valid only while the corresponding ack is high
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_oe  out  1  SRAM output enable
- sram_waddr  out  WORD_AW  SRAM word address
- sram_din  out  DW  SRAM write data
- sram_sel  out  SW  SRAM byte selects
- sram_dout  in  DW  SRAM read data, registered inside the SRAM one clock after the issue edge

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (master 0 wins the first tie).
  - m0_ack, m1_ack, sram_ce, sram_we, sram_oe = 0.
  - sram_waddr, sram_din, sram_sel = 0.
- All sram_* outputs are registered.
- rdata = sram_dout, combinational pass-through.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose the winner, latch its we/waddr/din/sel into the sram_* registers, set sram_ce=1, sram_we=winner_we, sram_oe=!winner_we, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - The SRAM samples at the end of this cycle.
  - Next-state registers: sram_we=0, sram_ce=0, go to RESP.
  - Address, data and sel are held.
- RESP (1 cycle):
  - ack of the winner = 1; for a read, sram_dout is valid in this cycle.
  - last_grant <= winner.
  - The current winner is excluded from arbitration in this cycle, because its req is still high.
  - If the other master requests: latch it and go to ISSUE (back-to-back).
  - Otherwise: go to IDLE; sram_oe <= 0.
- Timing:
  - Req seen in IDLE at edge N → SRAM access at edge N+1 → ack high during cycle N+2.
  - Sustained throughput with both masters requesting: one access per 2 cycles, alternating.
- Arbitration with the macro defined: round-robin; on a simultaneous request, the master != last_grant wins.
- Master handshake rules:
  - The master drops req, or presents a new request, in the cycle after ack.
  - A req seen in the cycle after its own ack is a new request.
  - Changing qualifiers while req is high and before ack is illegal; the latched values are used.
- sel=0 with we=1: the cycle is still issued and acked; the SRAM is unchanged.
- Reset mid-operation:
  - Outputs clear immediately and no ack is produced.
  - If the reset lands in ISSUE before the clock edge, the write is not performed.
- Address is not range-checked; wrap-around is the SRAM's responsibility.

Optional Feature:
- Macro: SOC_SRAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as above, using last_grant.
- Undefined:
  - Fixed priority, master 0 > master 1, in IDLE.
  - The RESP exclusion rule still applies, so after a master-0 access a pending master-1 request is served next. This bounds starvation to one access.
  - last_grant is not implemented.

Test Plan:
- Read: m0 read of waddr=0x10 preloaded with 0xDEADBEEF → sram_we never 1; m0_ack high 2 cycles after req; rdata=0xDEADBEEF during the ack.
- Byte write: m1 write waddr=0x4, din=0x11223344, sel=4'b0101 over 0xAABBCCDD, then m1 read → rdata=0xAA22CC44.
- Simultaneous requests, round-robin:
  - Stimulus: m0 and m1 both request from reset and are held.
  - Required grants: m0, m1, m0, m1.
  - Required acks: at cycles 2, 4, 6, 8; sram_we pulses exactly 1 cycle each.
- Reset during ISSUE of an m0 write to 0x8 → no ack; a later read of 0x8 returns the old value; all outputs go to 0 asynchronously.
- Macro undefined, fixed priority:
  - Stimulus: m0 requests continuously, m1 requests once.
  - Required: m1 is served immediately after the first m0 ack, then m0 resumes.
- Idle: no req for 20 cycles → sram_ce=sram_we=0 throughout; no acks.

Source files
------------

// File: rtl/soc_sram_sp_arbiter_if.sv
// ----------------------------------------------------------------------------
// soc_sram_sp_arbiter_if
// Bundles the two master request channels, the shared read-data return and
// the single-port SRAM control/address/data lines that the arbiter sits on.
//
// Parameters:
//   DW       data width (8, 16 or 32)
//   WORD_AW  word address width
//
// Signals:
//   mN_req/mN_we/mN_waddr/mN_din/mN_sel  request from master N (N = 0, 1)
//   mN_ack                               one-cycle completion pulse to master N
//   rdata                                read data, valid while an ack is high
//   sram_ce/sram_we/sram_oe              SRAM control strobes
//   sram_waddr/sram_din/sram_sel         SRAM address, write data, byte selects
//   sram_dout                            SRAM registered read data
//
// Modports:
//   slave   the arbiter's view (takes requests, drives the SRAM)
//   master  the environment's view (masters plus the SRAM macro)
//
// Handshake: a master raises mN_req with its qualifiers and holds all of them
// stable until it sees mN_ack high for exactly one cycle. The request is
// consumed on that cycle; a req still high in the following cycle is a new
// request. There is no back-pressure other than the delay to the ack.
// ----------------------------------------------------------------------------
interface soc_sram_sp_arbiter_if #(
    parameter int DW      = 32,
    parameter int WORD_AW = 30
);
    localparam int SW = (DW == 32) ? 4 : (DW == 16) ? 2 : 1;

    logic               m0_req;
    logic               m0_we;
    logic [WORD_AW-1:0] m0_waddr;
    logic [DW-1:0]      m0_din;
    logic [SW-1:0]      m0_sel;
    logic               m0_ack;

    logic               m1_req;
    logic               m1_we;
    logic [WORD_AW-1:0] m1_waddr;
    logic [DW-1:0]      m1_din;
    logic [SW-1:0]      m1_sel;
    logic               m1_ack;

    logic [DW-1:0]      rdata;

    logic               sram_ce;
    logic               sram_we;
    logic               sram_oe;
    logic [WORD_AW-1:0] sram_waddr;
    logic [DW-1:0]      sram_din;
    logic [SW-1:0]      sram_sel;
    logic [DW-1:0]      sram_dout;

    modport slave (
        input  m0_req, m0_we, m0_waddr, m0_din, m0_sel,
        input  m1_req, m1_we, m1_waddr, m1_din, m1_sel,
        output m0_ack, m1_ack, rdata,
        output sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel,
        input  sram_dout
    );

    modport master (
        output m0_req, m0_we, m0_waddr, m0_din, m0_sel,
        output m1_req, m1_we, m1_waddr, m1_din, m1_sel,
        input  m0_ack, m1_ack, rdata,
        input  sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel,
        output sram_dout
    );
endinterface

// File: rtl/soc_sram_sp_arbiter.sv
// ----------------------------------------------------------------------------
// soc_sram_sp_arbiter
// Arbitrates two masters (instruction fetch, data access) onto one
// single-port, byte-selectable SRAM with a 1-cycle registered read. One
// access is in flight at a time: IDLE -> ISSUE (SRAM samples at the end of
// this cycle) -> RESP (ack to the winner, read data valid) -> IDLE, or
// straight back to ISSUE when the other master is waiting.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   bus        soc_sram_sp_arbiter_if.slave (master channels + SRAM lines)
//   dbg_state  current FSM state (IDLE=0, ISSUE=1, RESP=2)
//
// Build option:
//   SOC_SRAM_ARB_ROUND_ROBIN_EN  defined: round-robin on simultaneous
//                                requests using last_grant.
//                                undefined: fixed priority, master 0 first.
//   In both builds the master just served is excluded in RESP, so a waiting
//   master is never passed over more than once.
// ----------------------------------------------------------------------------
module soc_sram_sp_arbiter #(
    parameter int DW      = 32,
    parameter int WORD_AW = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    soc_sram_sp_arbiter_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int SW = (DW == 32) ? 4 : (DW == 16) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   winner;        // master owning the access in flight

`ifdef SOC_SRAM_ARB_ROUND_ROBIN_EN
    logic   last_grant;    // master served most recently
`endif

    logic               any_req;
    logic               pick;       // IDLE arbitration result
    logic               other_req;  // the non-winner's request, seen in RESP
    logic               load;       // start a new access this cycle
    logic               grant_sel;
    logic               g_we;
    logic [WORD_AW-1:0] g_waddr;
    logic [DW-1:0]      g_din;
    logic [SW-1:0]      g_sel;

    assign any_req   = bus.m0_req | bus.m1_req;
    assign other_req = winner ? bus.m0_req : bus.m1_req;

`ifdef SOC_SRAM_ARB_ROUND_ROBIN_EN
    // On a tie the master that was not served last goes first.
    assign pick = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
`else
    assign pick = ~bus.m0_req;
`endif

    // In RESP the winner's req is still its old request, so only the other
    // master may be chained back-to-back.
    assign grant_sel = (state == RESP) ? ~winner : pick;
    assign load      = ((state == IDLE) && any_req) || ((state == RESP) && other_req);

    always_comb begin
        g_we    = bus.m0_we;
        g_waddr = bus.m0_waddr;
        g_din   = bus.m0_din;
        g_sel   = bus.m0_sel;
        if (grant_sel) begin
            g_we    = bus.m1_we;
            g_waddr = bus.m1_waddr;
            g_din   = bus.m1_din;
            g_sel   = bus.m1_sel;
        end
    end

    // The SRAM registers its output, so read data passes straight through.
    assign bus.rdata = bus.sram_dout;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            winner         <= 1'b0;
`ifdef SOC_SRAM_ARB_ROUND_ROBIN_EN
            last_grant     <= 1'b1;
`endif
            bus.m0_ack     <= 1'b0;
            bus.m1_ack     <= 1'b0;
            bus.sram_ce    <= 1'b0;
            bus.sram_we    <= 1'b0;
            bus.sram_oe    <= 1'b0;
            bus.sram_waddr <= '0;
            bus.sram_din   <= '0;
            bus.sram_sel   <= '0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) state <= ISSUE;
                end
                ISSUE: begin
                    // The write strobe lives for this single cycle only.
                    bus.sram_ce <= 1'b0;
                    bus.sram_we <= 1'b0;
                    if (winner) bus.m1_ack <= 1'b1;
                    else        bus.m0_ack <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
`ifdef SOC_SRAM_ARB_ROUND_ROBIN_EN
                    last_grant <= winner;
`endif
                    if (other_req) begin
                        state <= ISSUE;
                    end else begin
                        bus.sram_oe <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                winner         <= grant_sel;
                bus.sram_ce    <= 1'b1;
                bus.sram_we    <= g_we;
                bus.sram_oe    <= ~g_we;
                bus.sram_waddr <= g_waddr;
                bus.sram_din   <= g_din;
                bus.sram_sel   <= g_sel;
            end
        end
    end
endmodule

// File: tb/tb_soc_sram_sp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_soc_sram_sp_arbiter
// Directed bench for soc_sram_sp_arbiter with a behavioural byte-selectable
// SRAM (registered read) hanging off the SRAM side of the interface.
// ----------------------------------------------------------------------------
module tb_soc_sram_sp_arbiter;
    localparam int DW      = 32;
    localparam int WORD_AW = 30;
    localparam int SW      = (DW == 32) ? 4 : (DW == 16) ? 2 : 1;
    localparam int ISSUE_W = 3 + WORD_AW + SW + DW;
    localparam int OUT_W   = 5 + WORD_AW + DW + SW;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    soc_sram_sp_arbiter_if #(.DW(DW), .WORD_AW(WORD_AW)) bus ();

    soc_sram_sp_arbiter #(.DW(DW), .WORD_AW(WORD_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h04] = 32'hAABB_CCDD;
        mem[8'h08] = 32'h5566_7788;
        bus.sram_dout = '0;
        forever begin
            @(posedge clk);
            if (bus.sram_ce) begin
                if (bus.sram_we) begin
                    for (int b = 0; b < SW; b++)
                        if (bus.sram_sel[b]) mem[bus.sram_waddr[7:0]][8*b +: 8] <= bus.sram_din[8*b +: 8];
                end else begin
                    bus.sram_dout <= mem[bus.sram_waddr[7:0]];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int asserts = 0;
    int fails   = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic [WORD_AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_waddr = a; bus.m0_din = d; bus.m0_sel = s;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_waddr = a; bus.m1_din = d; bus.m1_sel = s;
        end
    endtask

    function automatic logic [OUT_W-1:0] outs();
        return {bus.m0_ack, bus.m1_ack, bus.sram_ce, bus.sram_we, bus.sram_oe,
                bus.sram_waddr, bus.sram_din, bus.sram_sel};
    endfunction

    // Single access with an idle cycle afterwards. Reads take their expected
    // data from exp_q.
    task automatic do_access(input int m, input logic we, input logic [WORD_AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s, input string name);
        logic [ISSUE_W-1:0] exp_issue;
        logic [ISSUE_W-1:0] act_issue;
        logic [DW-1:0]      exp_rd;
        logic               own_ack;
        logic               oth_ack;
        int                 lat;
        int                 we_hi;
        lat   = 0;
        we_hi = 0;
        drive(m, 1'b1, we, a, d, s);
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            own_ack = (m == 0) ? bus.m0_ack : bus.m1_ack;
            oth_ack = (m == 0) ? bus.m1_ack : bus.m0_ack;
            if (bus.sram_we === 1'b1) we_hi++;
            if (c == 1) begin
                exp_issue = {1'b1, we, ~we, a, s, d};
                act_issue = {bus.sram_ce, bus.sram_we, bus.sram_oe, bus.sram_waddr, bus.sram_sel, bus.sram_din};
                asserts++;
                if (act_issue !== exp_issue) begin
                    fails++;
                    $display("FAIL %s issue_lines: got %h want %h", name, act_issue, exp_issue);
                end
            end
            asserts++;
            if (oth_ack !== 1'b0) begin
                fails++;
                $display("FAIL %s other_ack c=%0d: got %b want 0", name, c, oth_ack);
            end
            if (own_ack === 1'b1) begin
                lat = c;
                asserts++;
                if (bus.sram_ce !== 1'b0) begin
                    fails++;
                    $display("FAIL %s ce_in_resp: got %b want 0", name, bus.sram_ce);
                end
                if (!we) begin
                    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    asserts++;
                    if (bus.rdata !== exp_rd) begin
                        fails++;
                        $display("FAIL %s rdata: got %h want %h", name, bus.rdata, exp_rd);
                    end
                end
            end
        end
        drive(m, 1'b0, we, a, d, s);
        asserts++;
        if (lat != 2) begin
            fails++;
            $display("FAIL %s ack_latency (0=timeout): got %0d want 2", name, lat);
        end
        asserts++;
        if (we_hi != (we ? 1 : 0)) begin
            fails++;
            $display("FAIL %s we_pulse_cycles: got %0d want %0d", name, we_hi, we ? 1 : 0);
        end
        tick();
        asserts++;
        if (dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL %s back_to_idle: got %0d want 0", name, dbg_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        asserts++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        asserts++;
        if (dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            tick();
            asserts++;
            if ({bus.sram_ce, bus.sram_we, bus.m0_ack, bus.m1_ack} !== 4'b0000) begin
                fails++;
                $display("FAIL idle c=%0d ce/we/ack0/ack1: got %b want 0000", c,
                         {bus.sram_ce, bus.sram_we, bus.m0_ack, bus.m1_ack});
            end
        end
    endtask

    task automatic test_read();
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(0, 1'b0, 30'h10, 32'h0, 4'hF, "m0_read");
    endtask

    task automatic test_byte_write();
        do_access(1, 1'b1, 30'h4, 32'h1122_3344, 4'b0101, "m1_byte_write");
        exp_q.push_back(32'hAA22_CC44);
        do_access(1, 1'b0, 30'h4, 32'h0, 4'hF, "m1_read_back");
    endtask

    task automatic test_back_to_back();
        logic [9:0]         m0_bits;
        logic [9:0]         m1_bits;
        logic [9:0]         we_bits;
        logic [WORD_AW-1:0] exp_a;
        m0_bits = '0; m1_bits = '0; we_bits = '0;
        drive(0, 1'b1, 1'b1, 30'h20, 32'h0BAD_F00D, 4'hF);
        drive(1, 1'b1, 1'b1, 30'h21, 32'hCAFE_1234, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            tick();
            m0_bits[c] = bus.m0_ack;
            m1_bits[c] = bus.m1_ack;
            we_bits[c] = bus.sram_we;
            if (bus.sram_we === 1'b1) begin
                exp_a = (c % 4 == 1) ? 30'h20 : 30'h21;
                asserts++;
                if (bus.sram_waddr !== exp_a) begin
                    fails++;
                    $display("FAIL b2b_addr c=%0d: got %h want %h", c, bus.sram_waddr, exp_a);
                end
            end
            if (c == 8) begin
                drive(0, 1'b0, 1'b0, '0, '0, '0);
                drive(1, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        asserts++;
        if (m0_bits !== 10'h044) begin
            fails++;
            $display("FAIL b2b_m0_acks: got %h want 044", m0_bits);
        end
        asserts++;
        if (m1_bits !== 10'h110) begin
            fails++;
            $display("FAIL b2b_m1_acks: got %h want 110", m1_bits);
        end
        asserts++;
        if (we_bits !== 10'h0AA) begin
            fails++;
            $display("FAIL b2b_we_pulses: got %h want 0aa", we_bits);
        end
        tick();
        exp_q.push_back(32'h0BAD_F00D);
        do_access(0, 1'b0, 30'h20, 32'h0, 4'hF, "b2b_read_20");
        exp_q.push_back(32'hCAFE_1234);
        do_access(1, 1'b0, 30'h21, 32'h0, 4'hF, "b2b_read_21");
    endtask

    // m0 keeps requesting, m1 asks once: m1 must slot in after m0's first ack.
    task automatic test_fixed_priority();
        logic [9:0]    m0_bits;
        logic [9:0]    m1_bits;
        logic [DW-1:0] exp_rd;
        m0_bits = '0; m1_bits = '0;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hAA22_CC44);
        exp_q.push_back(32'hDEAD_BEEF);
        drive(0, 1'b1, 1'b0, 30'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 30'h4, 32'h0, 4'hF);
        for (int c = 1; c <= 6; c++) begin
            tick();
            m0_bits[c] = bus.m0_ack;
            m1_bits[c] = bus.m1_ack;
            if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
                exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                asserts++;
                if (bus.rdata !== exp_rd) begin
                    fails++;
                    $display("FAIL prio_rdata c=%0d: got %h want %h", c, bus.rdata, exp_rd);
                end
            end
            if (bus.m1_ack === 1'b1) drive(1, 1'b0, 1'b0, '0, '0, '0);
            if (c == 6) drive(0, 1'b0, 1'b0, '0, '0, '0);
        end
        asserts++;
        if (m0_bits !== 10'h044) begin
            fails++;
            $display("FAIL prio_m0_acks: got %h want 044", m0_bits);
        end
        asserts++;
        if (m1_bits !== 10'h010) begin
            fails++;
            $display("FAIL prio_m1_acks: got %h want 010", m1_bits);
        end
        tick();
    endtask

    // Master 0 was served last; a fresh tie shows the arbitration policy.
    task automatic test_arb_policy();
        logic [9:0]    m0_bits;
        logic [9:0]    m1_bits;
        logic [9:0]    exp_m0;
        logic [9:0]    exp_m1;
        logic [DW-1:0] exp_rd;
`ifdef SOC_SRAM_ARB_ROUND_ROBIN_EN
        exp_m0 = 10'h010; exp_m1 = 10'h004;
`else
        exp_m0 = 10'h004; exp_m1 = 10'h010;
`endif
        m0_bits = '0; m1_bits = '0;
        drive(0, 1'b1, 1'b0, 30'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 30'h4, 32'h0, 4'hF);
        for (int c = 1; c <= 4; c++) begin
            tick();
            m0_bits[c] = bus.m0_ack;
            m1_bits[c] = bus.m1_ack;
            if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
                exp_rd = (bus.m0_ack === 1'b1) ? 32'hDEAD_BEEF : 32'hAA22_CC44;
                asserts++;
                if (bus.rdata !== exp_rd) begin
                    fails++;
                    $display("FAIL policy_rdata c=%0d: got %h want %h", c, bus.rdata, exp_rd);
                end
            end
            if (bus.m0_ack === 1'b1) drive(0, 1'b0, 1'b0, '0, '0, '0);
            if (bus.m1_ack === 1'b1) drive(1, 1'b0, 1'b0, '0, '0, '0);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        asserts++;
        if (m0_bits !== exp_m0) begin
            fails++;
            $display("FAIL policy_m0_acks: got %h want %h", m0_bits, exp_m0);
        end
        asserts++;
        if (m1_bits !== exp_m1) begin
            fails++;
            $display("FAIL policy_m1_acks: got %h want %h", m1_bits, exp_m1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 1'b1, 30'h8, 32'hFFFF_FFFF, 4'hF);
        tick();
        asserts++;
        if ({bus.sram_ce, bus.sram_we} !== 2'b11) begin
            fails++;
            $display("FAIL rstmid_issue: got %b want 11", {bus.sram_ce, bus.sram_we});
        end
        #2 rst_n = 1'b0;
        #1;
        asserts++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL rstmid_async_clear: got %h want 0", outs());
        end
        asserts++;
        if (dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_state: got %0d want 0", dbg_state);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            asserts++;
            if ({bus.m0_ack, bus.m1_ack, bus.sram_ce} !== 3'b000) begin
                fails++;
                $display("FAIL rstmid_no_ack c=%0d: got %b want 000", c, {bus.m0_ack, bus.m1_ack, bus.sram_ce});
            end
        end
        exp_q.push_back(32'h5566_7788);
        do_access(0, 1'b0, 30'h8, 32'h0, 4'hF, "rstmid_read_old");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_idle();
        test_read();
        test_byte_write();
        test_back_to_back();
        test_fixed_priority();
        test_arb_policy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
